// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access helpers for the load/store unit
// Contents:
//   lsu_state_t      FSM state encoding
//   F3_*             RV32I funct3 codes for loads/stores
//   f3_legal()       1 when funct3 is a legal load (or store) encoding
//   f3_size_m1()     access size in bytes minus one for a legal funct3
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] f3_size_m1(input logic [2:0] f3);
        logic [1:0] s;
        case (f3)
            F3_H, F3_HU: s = 2'd1;
            F3_W:        s = 2'd3;
            default:     s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - pipeline-side request/response bundle of the load/store unit
// Modports:
//   master  pipeline side: drives req_*, resp_ready; observes req_ready, resp_*
//   slave   load/store unit side: the mirror image
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic        resp_fault;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_misaligned, resp_fault
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_misaligned, resp_fault
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational lane select/extend for loads and byte/half merge for stores
// Ports:
//   funct3     in   access size/sign
//   addr_lo    in   byte offset within the word
//   word       in   word read from memory
//   wdata      in   store data (low byte/half used for SB/SH)
//   load_data  out  selected lane, sign- or zero-extended
//   merged     out  word with the target lane replaced (SW: wdata itself)
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_shifted;

    always_comb begin
        byte_shift   = {addr_lo, 3'b000};
        half_shift   = {addr_lo[1], 4'b0000};
        byte_shifted = word >> byte_shift;
        byte_sel     = byte_shifted[7:0];
        half_sel     = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = word;
            default: load_data = 32'h0;
        endcase

        // Clear the target lane, then OR in the shifted store bits.
        case (funct3)
            F3_B:    merged = (word & ~(32'h0000_00FF << byte_shift))
                              | ({24'h0, wdata[7:0]} << byte_shift);
            F3_H:    merged = (word & ~(32'h0000_FFFF << half_shift))
                              | ({16'h0, wdata[15:0]} << half_shift);
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a word-wide DataMemory port
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   pipe        lsu_if.slave request/response handshake with the pipeline
//   mem_addr    word-aligned address, 0 when no strobe
//   mem_wdata   full word to write
//   mem_read    read strobe (memory answers combinationally on mem_rdata)
//   mem_write   write strobe
//   mem_rdata   read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        pipe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE) << 2;

    lsu_state_t  state;
    logic        q_is_store;
    logic [2:0]  q_f3;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [31:0] q_wword;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;
    logic        resp_mis_q;
    logic        resp_fault_q;

    logic        in_legal;
    logic        in_misaligned;
    logic        in_out_of_range;
    logic [32:0] in_last_byte;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    // Request classification on the incoming (not yet latched) fields.
    always_comb begin
        in_legal     = f3_legal(pipe.req_is_store, pipe.req_funct3);
        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        in_last_byte = {1'b0, pipe.req_addr} + 33'(f3_size_m1(pipe.req_funct3));
        in_out_of_range = (in_last_byte >= MEM_BYTES);
        case (pipe.req_funct3)
            F3_H, F3_HU: in_misaligned = pipe.req_addr[0];
            F3_W:        in_misaligned = (pipe.req_addr[1:0] != 2'b00);
            default:     in_misaligned = 1'b0;
        endcase
    end

    lsu_byte_lane u_lane (
        .funct3    (q_f3),
        .addr_lo   (q_addr[1:0]),
        .word      (mem_rdata),
        .wdata     (q_wdata),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            q_is_store   <= 1'b0;
            q_f3         <= 3'b000;
            q_addr       <= 32'h0;
            q_wdata      <= 32'h0;
            q_wword      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_rd_q    <= 5'd0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pipe.req_valid) begin
                        q_is_store   <= pipe.req_is_store;
                        q_f3         <= pipe.req_funct3;
                        q_addr       <= pipe.req_addr;
                        q_wdata      <= pipe.req_wdata;
                        q_wword      <= pipe.req_wdata;
                        resp_rd_q    <= pipe.req_rd;
                        resp_data_q  <= 32'h0;
                        resp_mis_q   <= 1'b0;
                        resp_fault_q <= 1'b0;
                        if (!in_legal) begin
                            resp_fault_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (in_misaligned) begin
                            // Misalignment wins over range fault.
                            resp_mis_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (in_out_of_range) begin
                            resp_fault_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (!pipe.req_is_store) begin
                            state <= LOAD;
                        end else if (pipe.req_funct3 == F3_W) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_data_q  <= lane_load;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RMW_RD: begin
                    q_wword <= lane_merged;
                    state   <= WRITE;
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (pipe.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pipe.req_ready       = (state == IDLE);
    assign pipe.resp_valid      = resp_valid_q;
    assign pipe.resp_data       = resp_data_q;
    assign pipe.resp_rd         = resp_rd_q;
    assign pipe.resp_misaligned = resp_mis_q;
    assign pipe.resp_fault      = resp_fault_q;

    // Strobes are masked by rst directly so a reset cycle can never touch memory.
    assign mem_read  = !rst && ((state == LOAD) || (state == RMW_RD));
    assign mem_write = !rst && (state == WRITE);
    assign mem_addr  = (mem_read || mem_write) ? {q_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata = q_wword;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural DataMemory
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    lsu_if bus ();

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe      (bus.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk)
        if (mem_write && mem_addr < 32'h4000) mem[mem_addr[13:2]] = mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    // Response monitor: pops the scoreboard on each handshake, checks hold stability while stalled.
    int          first_cyc = -1;
    logic        held = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid) begin
            if (held) begin
                chk("hold_data", bus.resp_data, held_data);
                chk("hold_rd", 32'(bus.resp_rd), 32'(held_rd));
            end
            if (first_cyc < 0) first_cyc = cyc;
            if (bus.resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%h required=none", bus.resp_data);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"}, bus.resp_data, e.data);
                    chk({e.name, "_rd"}, 32'(bus.resp_rd), 32'(e.rd));
                    chk({e.name, "_mis"}, 32'(bus.resp_misaligned), 32'(e.mis));
                    chk({e.name, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
                    chk({e.name, "_lat"}, 32'(first_cyc - e.acc + 1), 32'(e.lat));
                end
                first_cyc = -1;
                held      = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = bus.resp_data;
                held_rd   = bus.resp_rd;
            end
        end
    end

    // Memory strobe logger.
    int          rd_cnt, wr_cnt;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
    always @(negedge clk) begin
        if (mem_read || mem_write) chk("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
        if (mem_read) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
        end
        if (mem_write) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
    end

    task automatic accept_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, output int acc);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] edata, input logic emis, input logic efault, input int elat);
        exp_t e;
        int   acc;
        rd_cnt = 0;
        wr_cnt = 0;
        accept_req(st, f3, addr, wdata, rd, acc);
        e.name = name; e.data = edata; e.rd = rd; e.mis = emis; e.fault = efault;
        e.lat = elat; e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] edata, input logic emis, input logic efault, input int elat,
                       input int erd, input int ewr);
        issue(name, st, f3, addr, wdata, rd, edata, emis, efault, elat);
        wait_idle();
        chk({name, "_rdcnt"}, 32'(rd_cnt), 32'(erd));
        chk({name, "_wrcnt"}, 32'(wr_cnt), 32'(ewr));
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);

        // Loads from word@0x100 = 0x80FF1234
        mem[32'h40] = 32'h80FF1234;
        run("lb_103",  0, F3_B,  32'h103, 0, 5'd1, 32'hFFFFFF80, 0, 0, 2, 1, 0);
        chk("lb_addr", last_rd_addr, 32'h100);
        run("lbu_103", 0, F3_BU, 32'h103, 0, 5'd2, 32'h00000080, 0, 0, 2, 1, 0);
        run("lh_102",  0, F3_H,  32'h102, 0, 5'd3, 32'hFFFF80FF, 0, 0, 2, 1, 0);
        run("lhu_102", 0, F3_HU, 32'h102, 0, 5'd4, 32'h000080FF, 0, 0, 2, 1, 0);
        run("lb_100",  0, F3_B,  32'h100, 0, 5'd5, 32'h00000034, 0, 0, 2, 1, 0);
        run("lw_100",  0, F3_W,  32'h100, 0, 5'd6, 32'h80FF1234, 0, 0, 2, 1, 0);

        // Read-modify-write stores into word@0x100 = 0x11223344
        mem[32'h40] = 32'h11223344;
        run("sb_101", 1, F3_B, 32'h101, 32'h000000AB, 5'd7, 32'h0, 0, 0, 3, 1, 1);
        chk("sb_wr_addr", last_wr_addr, 32'h100);
        chk("sb_wr_data", last_wr_data, 32'h1122AB44);
        chk("sb_mem", mem[32'h40], 32'h1122AB44);
        run("sh_102", 1, F3_H, 32'h102, 32'hCAFEBEEF, 5'd8, 32'h0, 0, 0, 3, 1, 1);
        chk("sh_mem", mem[32'h40], 32'hBEEFAB44);
        run("sw_104", 1, F3_W, 32'h104, 32'h12345678, 5'd9, 32'h0, 0, 0, 2, 0, 1);
        chk("sw_mem", mem[32'h41], 32'h12345678);

        // Misaligned / out-of-range / illegal: 1-cycle response, no strobes
        run("lw_mis",   0, F3_W,   32'h102,      0, 5'd10, 32'h0, 1, 0, 1, 0, 0);
        run("lh_mis",   0, F3_H,   32'h101,      0, 5'd11, 32'h0, 1, 0, 1, 0, 0);
        run("sw_oor",   1, F3_W,   32'h4000,     0, 5'd12, 32'h0, 0, 1, 1, 0, 0);
        run("ld_f3_011", 0, 3'b011, 32'h100,     0, 5'd13, 32'h0, 0, 1, 1, 0, 0);
        run("st_f3_100", 1, 3'b100, 32'h100,     0, 5'd14, 32'h0, 0, 1, 1, 0, 0);
        run("lw_wrap",  0, F3_W,   32'hFFFFFFFC, 0, 5'd15, 32'h0, 0, 1, 1, 0, 0);
        run("sw_mis_oor", 1, F3_W, 32'h3FFE,     0, 5'd16, 32'h0, 1, 0, 1, 0, 0);

        // Top-of-memory boundary
        mem[4095] = 32'hA5A50001;
        run("lw_top", 0, F3_W, 32'h3FFC, 0, 5'd17, 32'hA5A50001, 0, 0, 2, 1, 0);
        run("lh_top", 0, F3_H, 32'h3FFE, 0, 5'd18, 32'hFFFFA5A5, 0, 0, 2, 1, 0);

        // Backpressure: response held 3+ cycles, a new request must not be taken
        bus.resp_ready = 1'b0;
        issue("lw_bp", 0, F3_W, 32'h104, 0, 5'd19, 32'h12345678, 0, 0, 2);
        bus.req_is_store = 1'b0; bus.req_funct3 = F3_B; bus.req_addr = 32'h100;
        bus.req_rd = 5'd20; bus.req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("bp_rdcnt", 32'(rd_cnt), 32'd1);

        // Reset mid-LOAD
        accept_req(0, F3_B, 32'h100, 0, 5'd21, acc);
        chk("rl_mem_read_pre", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1 chk("rl_mem_read_rst", 32'(mem_read), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rl_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rl_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rl_mem_read", 32'(mem_read), 32'd0);
        chk("rl_resp_rd", 32'(bus.resp_rd), 32'd0);

        // Reset during the WRITE cycle of SW 0xDEADBEEF @0x10
        mem[4] = 32'h0BADF00D;
        accept_req(1, F3_W, 32'h10, 32'hDEADBEEF, 5'd22, acc);
        chk("rw_mem_write_pre", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1 chk("rw_mem_write_rst", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rw_mem", mem[4], 32'h0BADF00D);
        chk("rw_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rw_resp_valid", 32'(bus.resp_valid), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
